// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared CPU defines: ALU op codes, md op codes, md latencies
//
// Purpose: single home for the operation encodings used by the execute stage.
//          The HI/LO unit and its arithmetic core import the md encodings and the
//          default latencies from here, next to the ALU operation codes.
// Ports:   none (package).
package mult_div_unit_pkg;

    // ALU operation codes used by the E-stage ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Multiply/divide unit operation codes; 6 and 7 are unused and act as no-ops.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Default latencies, counted in cycles with busy asserted.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Width of the busy down-counter; latencies must fit in it.
    localparam int MD_CNT_W = 4;

    // True for the four operations that produce a multi-cycle result.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mt(input logic [2:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit product and quotient/remainder core
//
// Purpose: computes the HI/LO result of mult/multu/div/divu in one combinational
//          pass. The owning unit latches the result and hides the latency with a
//          counter, so no pipelining is done here.
// Ports:
//   A, B     in  32  rs/rt operands
//   mdop     in  3   operation code (md_op_e)
//   hi_res   out 32  product high word, or remainder
//   lo_res   out 32  product low word, or quotient
//   div_zero out 1   divide op with B == 0; result must not be committed
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  mdop,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] dsor_s;
    logic        [31:0] dsor_u;
    logic        [31:0] quo_m;
    logic        [31:0] rem_m;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               q_neg;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division is done on magnitudes. The magnitude of 0x80000000 is
    // 0x80000000 as an unsigned value, so 0x80000000 / -1 yields a magnitude
    // of 0x80000000 whose negation is itself, with remainder 0 -- the
    // overflow case needs no special path.
    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = B[31] ? (~B + 32'd1) : B;
    assign q_neg = A[31] ^ B[31];

    // The divisor is forced to 1 on zero only to keep the dividers defined;
    // div_zero suppresses the commit so these results are never seen.
    assign dsor_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign dsor_u = (B == 32'd0) ? 32'd1 : B;

    assign quo_m = abs_a / dsor_s;
    assign rem_m = abs_a % dsor_s;
    assign quo_u = A / dsor_u;
    assign rem_u = A % dsor_u;

    assign div_zero = md_is_div(mdop) && (B == 32'd0);

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (mdop)
            MD_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MD_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                lo_res = q_neg ? (~quo_m + 32'd1) : quo_m;
                hi_res = A[31] ? (~rem_m + 32'd1) : rem_m;
            end
            MD_DIVU: begin
                lo_res = quo_u;
                hi_res = rem_u;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - HI/LO multiply/divide unit with latency counter and stall
//
// Purpose: accepts mult/multu/div/divu from the E stage, latches the result at
//          once, then holds busy for a fixed latency before committing to HI/LO
//          in one step. mthi/mtlo write directly when idle. Stall freezes F/D
//          while a D-stage md/mt/mf instruction would race the unit.
// Ports:
//   clk       in  1   clock, rising edge
//   reset     in  1   synchronous active-high reset
//   start     in  1   E-stage mult/multu/div/divu, not flushed
//   mt_we     in  1   E-stage mthi/mtlo
//   mdop      in  3   operation code (md_op_e)
//   A, B      in  32  forwarded rs/rt operands
//   d_uses_md in  1   D-stage instruction is md, mt or mf
//   busy      out 1   multi-cycle operation in progress
//   stall     out 1   freeze F/D, bubble E
//   HI, LO    out 32  committed HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mt_we,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    logic [31:0]         hi_tmp;
    logic [31:0]         lo_tmp;
    logic [MD_CNT_W-1:0] cnt;
    logic                pending;

    logic [31:0]         hi_res;
    logic [31:0]         lo_res;
    logic                div_zero;

    logic                accept_op;
    logic                accept_mt;
    logic                last_cycle;
    logic [MD_CNT_W-1:0] load_val;

    mdu_arith u_arith (
        .A        (A),
        .B        (B),
        .mdop     (mdop),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    assign busy  = (cnt != '0);
    assign stall = d_uses_md & (start | busy);

    // start takes priority over mt_we even when its mdop is a no-op code,
    // so a combined start+mt_we never writes HI/LO directly.
    assign accept_op  = start & ~busy & md_is_arith(mdop);
    assign accept_mt  = mt_we & ~start & ~busy & md_is_mt(mdop);
    assign last_cycle = (cnt == MD_CNT_W'(1));
    assign load_val   = md_is_div(mdop) ? DIV_LOAD : MULT_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= 32'd0;
            LO      <= 32'd0;
            hi_tmp  <= 32'd0;
            lo_tmp  <= 32'd0;
            cnt     <= '0;
            pending <= 1'b0;
        end else if (accept_op) begin
            hi_tmp  <= hi_res;
            lo_tmp  <= lo_res;
            cnt     <= load_val;
            // Divide by zero still burns the full latency but never commits.
            pending <= ~div_zero;
        end else if (busy) begin
            cnt <= cnt - MD_CNT_W'(1);
            if (last_cycle) begin
                pending <= 1'b0;
                if (pending) begin
                    HI <= hi_tmp;
                    LO <= lo_tmp;
                end
            end
        end else if (accept_mt) begin
            if (mdop == MD_MTHI) begin
                HI <= A;
            end else begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mt_we;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fails;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mt_we     (mt_we),
        .mdop      (mdop),
        .A         (A),
        .B         (B),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .stall     (stall),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        mt_we     = 1'b0;
        mdop      = 3'd7;
        A         = 32'd0;
        B         = 32'd0;
        d_uses_md = 1'b0;
    endtask

    // Issue one arithmetic op and check busy/stall each cycle, that HI/LO keep
    // their old value until the commit, and the final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic d, input int cycles,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; mdop = op; A = a; B = b; d_uses_md = d;
        #1;
        check({tag, " stall@start"}, 32'(stall), 32'(d));
        tick();
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " stall"}, 32'(stall), 32'(d));
            check({tag, " hi hold"}, HI, old_hi);
            check({tag, " lo hold"}, LO, old_lo);
            tick();
        end
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " stall end"}, 32'(stall), 32'd0);
        check({tag, " HI"}, HI, exp_hi);
        check({tag, " LO"}, LO, exp_lo);
        d_uses_md = 1'b0;
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] a);
        mt_we = 1'b1; mdop = op; A = a;
        tick();
        mt_we = 1'b0; mdop = 3'd7; A = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);

        // Stall during a start with reset held: stall = d_uses_md & start.
        reset = 1'b1; start = 1'b1; mdop = 3'd0; d_uses_md = 1'b1;
        #1;
        check("reset stall start", 32'(stall), 32'd1);
        tick();
        check("reset dominates start", 32'(busy), 32'd0);
        idle_inputs();
        reset = 1'b0;

        // Signed vs unsigned multiply; first with d_uses_md held: 6 stall cycles.
        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE);

        // Signed vs unsigned divide.
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
               32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 1'b1, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10,
               32'd1, 32'd3, 32'd0, 32'h8000_0000);
        run_op("div pos-neg", 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 10,
               32'd0, 32'h8000_0000, 32'd1, 32'hFFFF_FFFD);

        // mthi/mtlo preset, then divide by zero leaves them unchanged.
        mt_write(3'd4, 32'h11);
        check("mthi HI", HI, 32'h11);
        check("mthi busy", 32'(busy), 32'd0);
        mt_write(3'd5, 32'h22);
        check("mtlo LO", LO, 32'h22);
        run_op("div0", 3'd2, 32'd5, 32'd0, 1'b0, 10,
               32'h11, 32'h22, 32'h11, 32'h22);

        // mdop 6 with start is a no-op.
        start = 1'b1; mdop = 3'd6; A = 32'd9; B = 32'd9;
        tick();
        idle_inputs();
        check("nop busy", 32'(busy), 32'd0);
        check("nop HI", HI, 32'h11);
        check("nop LO", LO, 32'h22);

        // mtlo and a second start while busy are both ignored.
        start = 1'b1; mdop = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        idle_inputs();
        tick();
        mt_we = 1'b1; mdop = 3'd5; A = 32'h0000_ABCD;
        tick();
        check("mtlo busy LO", LO, 32'h22);
        mt_we = 1'b0; start = 1'b1; mdop = 3'd3; A = 32'd100; B = 32'd3;
        tick();
        idle_inputs();
        check("start busy ignored", 32'(busy), 32'd1);
        tick();
        check("mult 3x4 last busy", 32'(busy), 32'd1);
        tick();
        check("mult 3x4 done", 32'(busy), 32'd0);
        check("mult 3x4 HI", HI, 32'd0);
        check("mult 3x4 LO", LO, 32'd12);
        mt_write(3'd5, 32'h0000_ABCD);
        check("mtlo idle LO", LO, 32'h0000_ABCD);
        check("mtlo idle busy", 32'(busy), 32'd0);

        // Reset in the third busy cycle of div 100/7 aborts with no commit.
        start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        idle_inputs();
        tick();
        tick();
        check("abort busy pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort no commit HI", HI, 32'd0);
        check("abort no commit LO", LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: start  input  1  E-stage mult/multu/div/divu present and not flushed.
REQ-004 SHALL provide port: mt_we  input  1  E-stage mthi/mtlo present.
REQ-005 SHALL provide port: mdop  input  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
REQ-006 SHALL provide port: A  input  32  rs operand (forwarded).
REQ-007 SHALL provide port: B  input  32  rt operand (forwarded).
REQ-008 SHALL provide port: d_uses_md  input  1  D-stage instruction is md, mt or mf.
REQ-009 SHALL provide port: busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL provide port: stall  output  1  freeze F/D, bubble E.
REQ-011 SHALL provide port: HI  output  32  committed HI register.
REQ-012 SHALL provide port: LO  output  32  committed LO register.
REQ-013 SHALL provide parameters: MULT_CYCLES default 5, mult latency in busy cycles; DIV_CYCLES default 10, div latency in busy cycles.

Function
REQ-014 State SHALL be: HI, LO, result latches hi_tmp/lo_tmp, down-counter cnt (4 bits), pending-commit flag.
REQ-015 start=1 with cnt==0 at edge k SHALL latch the result of A,B per mdop into hi_tmp/lo_tmp and load cnt with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL equal (cnt!=0), combinationally from registered cnt; busy therefore holds for exactly N cycles following edge k.
REQ-017 cnt SHALL decrement by 1 per edge while nonzero; on the edge where cnt goes 1->0, HI<=hi_tmp and LO<=lo_tmp.
REQ-018 New HI/LO SHALL be visible in the first cycle with busy=0; no intermediate value SHALL appear on HI/LO.
REQ-019 mult: {HI,LO}=signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-020 div: LO=signed quotient truncated toward zero, HI=remainder with sign of A; divu: unsigned.
REQ-021 Signed overflow 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Division by zero (B==0) SHALL run the full DIV_CYCLES with busy=1 and then leave HI/LO unchanged.
REQ-023 mt_we=1 with cnt==0 SHALL write A to HI (MTHI) or LO (MTLO) at that edge, 1-cycle latency, busy stays 0.
REQ-024 start or mt_we while busy=1 SHALL be ignored, with no state change.
REQ-025 start and mt_we both asserted SHALL be treated as start; mt_we is ignored.
REQ-026 mdop values 6-7 SHALL be treated as no-op.
REQ-027 stall SHALL equal d_uses_md & (start | busy), combinational.

Reset
REQ-028 reset=1 at an edge SHALL set HI=0, LO=0, hi_tmp=0, lo_tmp=0, cnt=0; busy=0 and stall=d_uses_md&start follow combinationally.
REQ-029 reset mid-operation SHALL abort it with no commit to HI/LO; reset SHALL dominate start and mt_we in the same cycle.

Structure
REQ-030 mdop encodings and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared CPU defines package next to the ALUop codes.
REQ-031 Combinational 64-bit product and quotient/remainder SHALL be one sub-module, mdu_arith (inputs A, B, mdop; outputs hi_res, lo_res, div_zero).
REQ-032 The counter, commit and stall logic SHALL stay in mult_div_unit.

Verification
REQ-033 Signed vs unsigned mult: mult A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=1, LO=0xFFFFFFFE.
REQ-034 Signed vs unsigned div: div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-035 Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo; div A=5, B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-036 Stall window: d_uses_md=1 held from the start cycle of mult -> stall=1 for 6 consecutive cycles; d_uses_md=0 -> stall=0 throughout.
REQ-037 Reset abort: reset asserted in 3rd busy cycle of div A=100, B=7 -> next cycle busy=0, HI=0, LO=0, no later commit.
REQ-038 mt timing: mtlo A=0xABCD while busy -> LO unaffected; mtlo A=0xABCD while idle -> LO=0xABCD next cycle.
